// File: rtl/arch_defs_pkg.sv
// Shared definitions for the program loader: frame sync byte and loader FSM states.
package arch_defs_pkg;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: writes a SYNC/LEN/data[/CHK] frame into RAM from address 0 and
// holds the CPU in reset until a good frame is in. Define LOADER_CHECKSUM_EN to require the CHK byte.
module program_loader
  import arch_defs_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  restart,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  loader_state_t         state;
  loader_state_t         state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_W-1:0]      cnt;
  logic                  accept;
  logic                  len_take;
  logic                  data_take;
  logic                  last_byte;
  logic                  len_bad;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] chk_total;

  assign chk_total = sum + rx_data;
`endif

  assign rx_ready  = state inside {S_SYNC, S_LEN, S_DATA, S_CHK};
  // restart wins over a byte offered in the same cycle, so that byte is never consumed
  assign accept    = rx_valid && rx_ready && !restart;
  assign len_bad   = (rx_data == '0) || ({1'b0, rx_data} > (DATA_WIDTH + 1)'(DEPTH));
  assign len_take  = accept && (state == S_LEN) && !len_bad;
  assign data_take = accept && (state == S_DATA);
  assign last_byte = (cnt == CNT_W'(1));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = S_SYNC;
    end else if (accept) begin
      case (state)
        S_SYNC: if (rx_data == DATA_WIDTH'(LOADER_SYNC_BYTE)) state_next = S_LEN;
        S_LEN:  state_next = len_bad ? S_ERR : S_DATA;
        S_DATA: begin
          if (last_byte) begin
`ifdef LOADER_CHECKSUM_EN
            state_next = S_CHK;
`else
            state_next = S_DONE;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK:  state_next = (chk_total == '0) ? S_DONE : S_ERR;
`endif
        default: state_next = state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_SYNC;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr      <= '0;
      cnt       <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else if (restart) begin
      addr     <= '0;
      cnt      <= '0;
      ram_we   <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      ram_we <= data_take;
      if (len_take) begin
        cnt <= CNT_W'(rx_data);
      end
      if (data_take) begin
        ram_addr  <= addr;
        ram_wdata <= rx_data;
        cnt       <= cnt - CNT_W'(1);
        // Stop at the last written address so addr never wraps past the image.
        if (!last_byte) begin
          addr <= addr + ADDR_WIDTH'(1);
        end
      end
      // S_DONE is entered on the last accepted byte; releasing the CPU one edge later
      // lets the final RAM write land first.
      cpu_hold <= (state != S_DONE);
      if (state_next == S_DONE) done  <= 1'b1;
      if (state_next == S_ERR)  error <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset || restart) begin
      sum <= '0;
    end else if (data_take) begin
      sum <= sum + rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected RAM writes go into a scoreboard queue as bytes are driven
// and are popped by a monitor whenever ram_we is seen.
module tb_program_loader;
  import arch_defs_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam logic [7:0] PROG [8] = '{8'h85, 8'h7E, 8'h83, 8'h7D, 8'h4E, 8'h2D, 8'h00, 8'hFF};

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          restart = 1'b0;
  logic          rx_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;

  wr_t           sb[$];
  logic [DW-1:0] ram_model [2**AW];
  int            n_checks = 0;
  int            n_errors = 0;

  program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .restart   (restart),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Every write must match the head of the scoreboard; a write with nothing queued is spurious.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (ram_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_we", 32'(ram_we), 32'(0));
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(e.a));
        check("wr_data", 32'(ram_wdata), 32'(e.d));
      end
      ram_model[ram_addr] = ram_wdata;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("rx_ready", 32'(rx_ready), 32'(1));
    @(posedge clk);
  endtask

  task automatic push_wr(input int i);
    wr_t w;
    w.a = AW'(i);
    w.d = PROG[i];
    sb.push_back(w);
  endtask

  task automatic send_prog(input int gap);
    send_byte(LOADER_SYNC_BYTE);
    send_byte(8'h08);
    for (int i = 0; i < 8; i++) begin
      push_wr(i);
      send_byte(PROG[i]);
      if (gap > 0 && i < 7) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
  endtask

  task automatic finish_frame();
    @(negedge clk);
    rx_valid = 1'b0;
`ifndef LOADER_CHECKSUM_EN
    check("last_we", 32'(ram_we), 32'(1));
`endif
    check("done", 32'(done), 32'(1));
    check("error", 32'(error), 32'(0));
    check("hold_before", 32'(cpu_hold), 32'(1));
    @(negedge clk);
    check("hold_after", 32'(cpu_hold), 32'(0));
    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'(0));
  endtask

  task automatic clear_ram();
    foreach (ram_model[i]) ram_model[i] = 'x;
  endtask

  task automatic check_ram();
    for (int i = 0; i < 8; i++) check("ram", 32'(ram_model[i]), 32'(PROG[i]));
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    rx_valid = 1'b0;
    restart  = 1'b1;
    @(negedge clk);
    restart  = 1'b0;
    check("rst_done", 32'(done), 32'(0));
    check("rst_error", 32'(error), 32'(0));
    check("rst_hold", 32'(cpu_hold), 32'(1));
    check("rst_ready", 32'(rx_ready), 32'(1));
  endtask

  task automatic check_reset_vals();
    check("r_we", 32'(ram_we), 32'(0));
    check("r_addr", 32'(ram_addr), 32'(0));
    check("r_wdata", 32'(ram_wdata), 32'(0));
    check("r_hold", 32'(cpu_hold), 32'(1));
    check("r_done", 32'(done), 32'(0));
    check("r_error", 32'(error), 32'(0));
    check("r_ready", 32'(rx_ready), 32'(1));
  endtask

  initial begin : stimulus
    clear_ram();
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b1;

    // Test 1: plain frame, back-to-back bytes.
    send_prog(0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h83);
`endif
    finish_frame();
    check_ram();

    // Test 2: restart out of S_DONE, then junk before the sync byte.
    pulse_restart();
    clear_ram();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    send_prog(0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h83);
`endif
    finish_frame();
    check_ram();

    // Test 3: LEN of 0 and LEN of 17 are both rejected.
    pulse_restart();
    send_byte(LOADER_SYNC_BYTE);
    send_byte(8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    check("len0_error", 32'(error), 32'(1));
    check("len0_ready", 32'(rx_ready), 32'(0));
    check("len0_hold", 32'(cpu_hold), 32'(1));
    check("len0_done", 32'(done), 32'(0));
    pulse_restart();
    send_byte(LOADER_SYNC_BYTE);
    send_byte(8'h11);
    @(negedge clk);
    rx_valid = 1'b0;
    check("len17_error", 32'(error), 32'(1));
    check("len17_ready", 32'(rx_ready), 32'(0));
    check("len17_hold", 32'(cpu_hold), 32'(1));

    // Test 4: rx_valid toggling, then a stream that must stall in S_DONE.
    pulse_restart();
    clear_ram();
    send_prog(1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h83);
`endif
    finish_frame();
    check_ram();
    rx_data  = LOADER_SYNC_BYTE;
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_ready", 32'(rx_ready), 32'(0));
    end
    rx_valid = 1'b0;
    check("stall_done", 32'(done), 32'(1));

    // Test 5: bad checksum byte.
    pulse_restart();
    clear_ram();
    send_prog(0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h84);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("badchk_error", 32'(error), 32'(1));
    check("badchk_done", 32'(done), 32'(0));
    check("badchk_hold", 32'(cpu_hold), 32'(1));
`else
    @(negedge clk);
    rx_data = 8'h84;
    check("nochk_done", 32'(done), 32'(1));
    repeat (3) begin
      @(negedge clk);
      check("nochk_ready", 32'(rx_ready), 32'(0));
    end
    rx_valid = 1'b0;
    check("nochk_error", 32'(error), 32'(0));
    check("nochk_hold", 32'(cpu_hold), 32'(0));
`endif
    check("t5_sb_empty", 32'(sb.size()), 32'(0));
    check_ram();

    // Test 6a: reset after three data bytes, then a fresh frame.
    pulse_restart();
    clear_ram();
    send_byte(LOADER_SYNC_BYTE);
    send_byte(8'h08);
    for (int i = 0; i < 3; i++) begin
      push_wr(i);
      send_byte(PROG[i]);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    check_reset_vals();
    reset = 1'b1;
    clear_ram();
    send_prog(0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h83);
`endif
    finish_frame();
    check_ram();

    // Test 6b: restart coinciding with a data byte drops that byte.
    pulse_restart();
    send_byte(LOADER_SYNC_BYTE);
    send_byte(8'h08);
    push_wr(0);
    send_byte(PROG[0]);
    @(negedge clk);
    rx_data  = PROG[1];
    rx_valid = 1'b1;
    restart  = 1'b1;
    @(negedge clk);
    restart  = 1'b0;
    rx_valid = 1'b0;
    check("drop_we", 32'(ram_we), 32'(0));
    check("drop_done", 32'(done), 32'(0));
    check("drop_hold", 32'(cpu_hold), 32'(1));
    check("drop_ready", 32'(rx_ready), 32'(1));
    clear_ram();
    send_prog(0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h83);
`endif
    finish_frame();
    check_ram();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
